swivm_bytemem_ctl: RTL and testbench
====================================

# swivm_bytemem_ctl

Memory controller between the SwiVM CPU memory port and an 8-bit-wide synchronous byte RAM. It accepts one byte, halfword or word request at a time and serialises it into little-endian byte accesses. It assembles read data with optional sign extension and reports completion with a one-cycle acknowledge. The CPU's memory interface conventions (16-bit byte address, size codes, active-low write enable) are carried through unchanged.

## Interface
Parameters:
- none (address width fixed at 16, data width fixed at 32, RAM width fixed at 8)

Ports:
- i_clk  in  1  system clock; all state changes on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req  in  1  request strobe; sampled only in IDLE
- i_addr  in  16  byte address of lowest byte
- i_wrdata  in  32  write data; bits 7:0 go to i_addr
- i_size  in  2  00 byte, 10 halfword, 11 word; 01 treated as byte
- i_we_n  in  1  0 = write, 1 = read (CPU convention)
- i_signed  in  1  read only: 1 sign-extends byte/half results, 0 zero-extends
- o_rddata  out  32  assembled read result
- o_ack  out  1  one-cycle completion pulse
- o_busy  out  1  transaction in progress
- o_ram_addr  out  16  byte RAM address
- o_ram_wdata  out  8  byte RAM write data
- o_ram_we  out  1  byte RAM write enable, active-high
- i_ram_rdata  in  8  byte RAM read data, valid the cycle after the address is presented

## Operation
- States: IDLE, ISSUE, DRAIN (read only), DONE.
- IDLE: when i_req=1 at a clock edge, latch addr, wrdata, size, we_n and signed. Set byte count N (1/2/4) and k=0, then go to ISSUE. If i_req=0, stay.
- ISSUE, byte k:
  - o_ram_addr = latched addr + k, mod 2^16. Wrap-around is legal; no error is raised.
  - Write: o_ram_we=1, o_ram_wdata = wrdata[8k+7:8k].
  - Read: o_ram_we=0.
  - After byte N-1: a write goes to DONE, a read goes to DRAIN.
- Read capture: i_ram_rdata returned for byte k is stored into result bits 8k+7:8k in the following cycle. DRAIN captures the final byte, then goes to DONE.
- DONE:
  - o_ack=1 for exactly one cycle.
  - For reads, o_rddata is updated with the assembled value and held until the next read completes. Writes never alter o_rddata.
  - Extension: if signed, bits 31:8 (byte) or 31:16 (half) are copied from the top data bit; otherwise they are zeroed. Word reads ignore i_signed.
  - Next state IDLE.
- o_busy=1 in ISSUE, DRAIN and DONE; 0 in IDLE.
- i_req while busy is ignored and is not queued.
- o_ram_we=0 in every state except write ISSUE cycles. o_ram_addr and o_ram_wdata hold their last values outside ISSUE.

## Timing
- Cycle 0 is the cycle at whose end i_req is sampled high in IDLE.
- Write of N bytes:
  - o_ram_we high in cycles 1..N.
  - o_ack in cycle N+1.
  - Next request can be sampled at the end of cycle N+2.
- Read of N bytes:
  - Addresses in cycles 1..N; RAM data in cycles 2..N+1.
  - o_ack and valid o_rddata in cycle N+2.
- Latencies, request to ack:
  - Writes: byte 2, half 3, word 5 cycles.
  - Reads: byte 3, half 4, word 6 cycles.
- All outputs are registered. No combinational path exists from any input to any output.
- Reset (i_rst_n=0), at any time including mid-transaction:
  - Immediately: state IDLE, o_ack=0, o_busy=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_rddata=0.
  - A transaction in progress is aborted with no ack. Bytes already written remain in RAM.
- After reset deasserts, the first edge with i_req=1 starts a transaction.

## Test plan
- Word write then read, addr 0x0100, data 0x11223344 -> RAM[0x100..0x103] = 44,33,22,11. Write ack in cycle 5. Read ack in cycle 6 with o_rddata=0x11223344.
- Byte read of 0x80 at 0x0200 -> i_signed=1 gives 0xFFFFFF80, i_signed=0 gives 0x00000080. Ack in cycle 3. Size 01 gives the same result as 00.
- Halfword write 0xBEEF at 0xFFFF -> RAM[0xFFFF]=0xEF, RAM[0x0000]=0xBE (wrap). Signed half read returns 0xFFFFBEEF.
- i_req pulsed during a word read -> ignored. Exactly one ack occurs and o_rddata is unaffected. A request after return to IDLE is accepted.
- i_rst_n asserted in cycle 2 of a word write -> o_busy and o_ram_we drop to 0 at once and no ack occurs. RAM holds only byte 0 (byte 1 if the enable was already sampled). A post-reset byte read works normally.
- Back-to-back: a write followed immediately by a read of the same address -> the read returns the written data. o_rddata is unchanged by the intervening write.

Source files
------------

// File: rtl/swivm_bytemem_ctl.sv
// Byte-serialising memory controller: SwiVM CPU port to an 8-bit synchronous RAM.
// Multi-byte requests become little-endian byte accesses; reads are reassembled and extended.
module swivm_bytemem_ctl (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic [31:0] i_wrdata,
   input  logic [1:0]  i_size,
   input  logic        i_we_n,
   input  logic        i_signed,
   output logic [31:0] o_rddata,
   output logic        o_ack,
   output logic        o_busy,
   output logic [15:0] o_ram_addr,
   output logic [7:0]  o_ram_wdata,
   output logic        o_ram_we,
   input  logic [7:0]  i_ram_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t      state_q, state_nx;
   logic [1:0]  k_q, k_nx;          // byte currently presented to the RAM
   logic [1:0]  last_q, last_nx;    // index of the final byte (N-1)
   logic [1:0]  prev_k;
   logic [15:0] addr_q, addr_nx;
   logic [31:0] wdata_q, wdata_nx;
   logic        rd_q, rd_nx;
   logic        sgn_q, sgn_nx;
   logic [31:0] buf_q, buf_nx;
   logic [31:0] asm_w, ext_w;
   logic [31:0] rddata_nx;
   logic [15:0] ram_addr_nx;
   logic [7:0]  ram_wdata_nx;
   logic        ram_we_nx, ack_nx, busy_nx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_nx;
   end

   always_comb begin
      state_nx     = state_q;
      k_nx         = k_q;
      last_nx      = last_q;
      addr_nx      = addr_q;
      wdata_nx     = wdata_q;
      rd_nx        = rd_q;
      sgn_nx       = sgn_q;
      buf_nx       = buf_q;
      rddata_nx    = o_rddata;
      ram_addr_nx  = o_ram_addr;
      ram_wdata_nx = o_ram_wdata;
      ram_we_nx    = 1'b0;
      prev_k       = k_q - 2'd1;

      // Final byte arrives during DRAIN; fold it in and extend before registering.
      asm_w = buf_q;
      asm_w[{last_q, 3'b000} +: 8] = i_ram_rdata;
      ext_w = asm_w;
      case (last_q)
         2'd0:    ext_w[31:8]  = sgn_q ? {24{asm_w[7]}}  : 24'd0;
         2'd1:    ext_w[31:16] = sgn_q ? {16{asm_w[15]}} : 16'd0;
         default: ;
      endcase

      case (state_q)
         S_IDLE: begin
            if (i_req) begin
               addr_nx  = i_addr;
               wdata_nx = i_wrdata;
               rd_nx    = i_we_n;
               sgn_nx   = i_signed;
               case (i_size)
                  2'b10:   last_nx = 2'd1;
                  2'b11:   last_nx = 2'd3;
                  default: last_nx = 2'd0;
               endcase
               k_nx         = 2'd0;
               buf_nx       = '0;
               ram_addr_nx  = i_addr;
               ram_wdata_nx = i_wrdata[7:0];
               ram_we_nx    = ~i_we_n;
               state_nx     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // RAM data lags the address by one cycle, so capture the previous byte.
            if (rd_q && k_q != 2'd0) buf_nx[{prev_k, 3'b000} +: 8] = i_ram_rdata;
            if (k_q == last_q) begin
               state_nx = rd_q ? S_DRAIN : S_DONE;
            end else begin
               k_nx         = k_q + 2'd1;
               ram_addr_nx  = addr_q + {14'd0, k_nx};
               ram_wdata_nx = wdata_q[{k_nx, 3'b000} +: 8];
               ram_we_nx    = ~rd_q;
            end
         end
         S_DRAIN: begin
            rddata_nx = ext_w;
            state_nx  = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      ack_nx  = (state_nx == S_DONE);
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         k_q         <= '0;
         last_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= 1'b0;
         sgn_q       <= 1'b0;
         buf_q       <= '0;
         o_rddata    <= '0;
         o_ack       <= 1'b0;
         o_busy      <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
         o_ram_we    <= 1'b0;
      end else begin
         k_q         <= k_nx;
         last_q      <= last_nx;
         addr_q      <= addr_nx;
         wdata_q     <= wdata_nx;
         rd_q        <= rd_nx;
         sgn_q       <= sgn_nx;
         buf_q       <= buf_nx;
         o_rddata    <= rddata_nx;
         o_ack       <= ack_nx;
         o_busy      <= busy_nx;
         o_ram_addr  <= ram_addr_nx;
         o_ram_wdata <= ram_wdata_nx;
         o_ram_we    <= ram_we_nx;
      end
   end

endmodule

// File: tb/tb_swivm_bytemem_ctl.sv
// Bench for swivm_bytemem_ctl: directed vector table, corner sequences and a
// randomized run checked against a transaction-level memory model.
module tb_swivm_bytemem_ctl;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic [31:0] i_wrdata = '0;
   logic [1:0]  i_size = '0;
   logic        i_we_n = 1'b1;
   logic        i_signed = 1'b0;
   logic [31:0] o_rddata;
   logic        o_ack, o_busy, o_ram_we;
   logic [15:0] o_ram_addr;
   logic [7:0]  o_ram_wdata;
   logic [7:0]  i_ram_rdata = '0;

   swivm_bytemem_ctl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_addr(i_addr),
      .i_wrdata(i_wrdata), .i_size(i_size), .i_we_n(i_we_n), .i_signed(i_signed),
      .o_rddata(o_rddata), .o_ack(o_ack), .o_busy(o_busy), .o_ram_addr(o_ram_addr),
      .o_ram_wdata(o_ram_wdata), .o_ram_we(o_ram_we), .i_ram_rdata(i_ram_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Synchronous byte RAM
   bit [7:0] mem [0:65535];
   always @(posedge i_clk) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      i_ram_rdata <= mem[o_ram_addr];
   end

   // Reference model: memory image at transaction granularity
   bit [7:0]    ref_mem [0:65535];
   logic [31:0] last_rd = '0;
   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
   endfunction

   function automatic logic [31:0] ref_read(input logic [15:0] a, input int n, input bit sg);
      logic [31:0] v = 0;
      logic [15:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 16'(i);
         v = v + (32'(ref_mem[ai]) << (8 * i));
      end
      if (sg && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input int n);
      logic [15:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 16'(i);
         ref_mem[ai] = 8'((d >> (8 * i)) & 32'hFF);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the ack cycle.
   task automatic run_txn(input logic [15:0] a, input logic [31:0] wd, input logic [1:0] sz,
                          input bit we_n, input bit sg,
                          output logic [31:0] rd, output int lat, output int wecnt);
      i_req = 1'b1; i_addr = a; i_wrdata = wd; i_size = sz; i_we_n = we_n; i_signed = sg;
      @(negedge i_clk);
      i_req = 1'b0;
      lat = 0; wecnt = 0; rd = 'x;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         if (o_ram_we) wecnt++;
         if (o_ack) begin lat = c; rd = o_rddata; end
         @(negedge i_clk);
      end
      check("ack_one_cycle", {31'd0, o_ack}, 32'd0);
      check("idle_after_done", {31'd0, o_busy}, 32'd0);
   endtask

   // Runs a transaction and checks it against the model (latency, data, write enables).
   task automatic model_txn(input string tag, input logic [15:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input bit we_n, input bit sg);
      logic [31:0] rd, exp;
      int lat, wecnt, n;
      n = nbytes(sz);
      if (we_n) exp = ref_read(a, n, sg);
      else      exp = last_rd;
      run_txn(a, wd, sz, we_n, sg, rd, lat, wecnt);
      check({tag, "_lat"}, lat, we_n ? n + 2 : n + 1);
      check({tag, "_rddata"}, rd, exp);
      if (!we_n) begin
         check({tag, "_we_cycles"}, wecnt, n);
         ref_write(a, wd, n);
      end else last_rd = exp;
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      bit          we_n;
      bit          sgn;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0] rd;
      int lat, wecnt, acks;

      vecs[0]  = '{16'h0100, 32'h11223344, 2'b11, 1'b0, 1'b0, 32'h00000000, 5};
      vecs[1]  = '{16'h0100, 32'h0,        2'b11, 1'b1, 1'b0, 32'h11223344, 6};
      vecs[2]  = '{16'h0200, 32'h00000080, 2'b00, 1'b0, 1'b0, 32'h11223344, 2};
      vecs[3]  = '{16'h0200, 32'h0,        2'b00, 1'b1, 1'b1, 32'hFFFFFF80, 3};
      vecs[4]  = '{16'h0200, 32'h0,        2'b00, 1'b1, 1'b0, 32'h00000080, 3};
      vecs[5]  = '{16'h0200, 32'h0,        2'b01, 1'b1, 1'b1, 32'hFFFFFF80, 3};
      vecs[6]  = '{16'hFFFF, 32'h0000BEEF, 2'b10, 1'b0, 1'b0, 32'hFFFFFF80, 3};
      vecs[7]  = '{16'hFFFF, 32'h0,        2'b10, 1'b1, 1'b1, 32'hFFFFBEEF, 4};
      vecs[8]  = '{16'h0000, 32'h0,        2'b00, 1'b1, 1'b0, 32'h000000BE, 3};
      vecs[9]  = '{16'hFFFF, 32'h0,        2'b00, 1'b1, 1'b0, 32'h000000EF, 3};
      vecs[10] = '{16'hFFFF, 32'h0,        2'b10, 1'b1, 1'b0, 32'h0000BEEF, 4};
      vecs[11] = '{16'h0100, 32'h0,        2'b11, 1'b1, 1'b1, 32'h11223344, 6};

      // Reset state
      repeat (2) @(negedge i_clk);
      check("rst_ack", {31'd0, o_ack}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_we", {31'd0, o_ram_we}, 32'd0);
      check("rst_addr", {16'd0, o_ram_addr}, 32'd0);
      check("rst_wdata", {24'd0, o_ram_wdata}, 32'd0);
      check("rst_rddata", o_rddata, 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Directed table
      for (int v = 0; v < 12; v++) begin
         run_txn(vecs[v].addr, vecs[v].wdata, vecs[v].size, vecs[v].we_n, vecs[v].sgn, rd, lat, wecnt);
         check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
         check($sformatf("vec%0d_rddata", v), rd, vecs[v].exp_rd);
         if (!vecs[v].we_n) ref_write(vecs[v].addr, vecs[v].wdata, nbytes(vecs[v].size));
         if (v == 0) begin
            check("word_wr_b0", {24'd0, mem[16'h0100]}, 32'h44);
            check("word_wr_b3", {24'd0, mem[16'h0103]}, 32'h11);
         end
         if (v == 6) begin
            check("wrap_wr_ffff", {24'd0, mem[16'hFFFF]}, 32'hEF);
            check("wrap_wr_0000", {24'd0, mem[16'h0000]}, 32'hBE);
         end
      end
      last_rd = 32'h11223344;

      // Request while busy is ignored (here a stray word write to 0x0500)
      i_req = 1'b1; i_addr = 16'h0100; i_size = 2'b11; i_we_n = 1'b1; i_signed = 1'b0;
      @(negedge i_clk);
      i_req = 1'b0;
      acks = 0; lat = 0;
      for (int c = 1; c <= 14; c++) begin
         if (o_ack) begin acks++; lat = c; rd = o_rddata; end
         if (c == 2) begin
            i_req = 1'b1; i_addr = 16'h0500; i_wrdata = 32'hDEADBEEF; i_we_n = 1'b0;
         end
         if (c == 3) i_req = 1'b0;
         @(negedge i_clk);
      end
      check("busy_req_acks", acks, 1);
      check("busy_req_lat", lat, 6);
      check("busy_req_rddata", rd, 32'h11223344);
      check("busy_req_no_write", {24'd0, mem[16'h0500]}, 32'h0);
      model_txn("after_busy", 16'h0200, 32'h0, 2'b00, 1'b1, 1'b0);

      // Randomized traffic around both ends of the address space
      for (int t = 0; t < 300; t++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15))
                                          : 16'hFFF0 + 16'($urandom_range(0, 15));
         model_txn($sformatf("rnd%0d", t), a, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset in cycle 2 of a word write
      i_req = 1'b1; i_addr = 16'h0300; i_wrdata = 32'hA1B2C3D4; i_size = 2'b11; i_we_n = 1'b0;
      @(negedge i_clk);
      i_req = 1'b0;
      @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_we", {31'd0, o_ram_we}, 32'd0);
      check("midrst_addr", {16'd0, o_ram_addr}, 32'd0);
      check("midrst_rddata", o_rddata, 32'd0);
      acks = 0;
      repeat (3) begin
         @(negedge i_clk);
         if (o_ack) acks++;
      end
      i_rst_n = 1'b1;
      repeat (6) begin
         @(negedge i_clk);
         if (o_ack) acks++;
      end
      check("midrst_no_ack", acks, 0);
      check("midrst_b0", {24'd0, mem[16'h0300]}, 32'hD4);
      check("midrst_b1", {24'd0, mem[16'h0301]}, 32'h00);
      check("midrst_b3", {24'd0, mem[16'h0303]}, 32'h00);
      ref_mem[16'h0300] = 8'hD4;
      last_rd = '0;
      model_txn("post_rst_rd", 16'h0300, 32'h0, 2'b00, 1'b1, 1'b1);
      model_txn("post_rst_wd", 16'h0300, 32'h0, 2'b11, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
